// File: rtl/conv3x3_relu_pe_pkg.sv
// Shared types and constants for the 3x3 convolution + ReLU processing element.
// Also holds the sign-extension helper used by the row adders.
package conv3x3_relu_pe_pkg;

   typedef logic signed [7:0]  pixel_t;
   typedef logic signed [7:0]  weight_t;
   typedef logic signed [15:0] bias_t;
   typedef logic signed [15:0] product_t;

   localparam int NUM_TAPS  = 9;
   localparam int BIAS_SLOT = 9;
   localparam int ROW_SUM_W = 18;

   typedef logic signed [ROW_SUM_W-1:0] row_sum_t;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic row_sum_t sext_prod(input product_t p);
      return row_sum_t'(p);
   endfunction

endpackage

// File: rtl/conv3x3_relu_pe_requant_relu_sat.sv
// Combinational ReLU, round-half-up right shift and saturation to 0..127.
// Shared by every layer that requantises a wide accumulator back to int8.
module requant_relu_sat
   import conv3x3_relu_pe_pkg::*;
#(
   parameter int ACC_W = 20,
   parameter int SHIFT = 7
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output pixel_t                  q_o
);

   // One extra bit keeps the rounding add from wrapping near full scale.
   localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'((1 << SHIFT) >> 1);
   localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'(127);

   logic signed [ACC_W:0] acc_ext;
   logic signed [ACC_W:0] rounded;
   logic signed [ACC_W:0] shifted;

   assign acc_ext = {acc_i[ACC_W-1], acc_i};
   assign rounded = acc_ext + HALF;
   assign shifted = rounded >>> SHIFT;

   always_comb begin
      q_o = '0;
      if (!acc_i[ACC_W-1] && (acc_i != '0)) begin
         q_o = (shifted > PIX_MAX) ? pixel_t'(PIX_MAX[7:0]) : pixel_t'(shifted[7:0]);
      end
   end

endmodule

// File: rtl/conv3x3_relu_pe.sv
// 3x3 convolution processing element: serial kernel/bias load, 3-stage MAC
// pipeline, ReLU + requantisation to int8 and output position tracking.
module conv3x3_relu_pe
   import conv3x3_relu_pe_pkg::*;
#(
   parameter int OUT_W = 6,
   parameter int OUT_H = 6,
   parameter int SHIFT = 7,
   parameter int ACC_W = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       w_clear,
   input  logic                       w_valid,
   input  logic signed [15:0]         w_data,
   output logic                       loaded,
   input  logic                       valid_in,
   input  pixel_t                     win0,
   input  pixel_t                     win1,
   input  pixel_t                     win2,
   input  pixel_t                     win3,
   input  pixel_t                     win4,
   input  pixel_t                     win5,
   input  pixel_t                     win6,
   input  pixel_t                     win7,
   input  pixel_t                     win8,
   output pixel_t                     data_out,
   output logic                       valid_out,
   output logic [$clog2(OUT_W)-1:0]   out_col,
   output logic [$clog2(OUT_H)-1:0]   out_row,
   output logic                       frame_done,
   output logic                       drop_err
);

   localparam int COL_W = $clog2(OUT_W);
   localparam int ROW_W = $clog2(OUT_H);

   state_t       state_q, state_d;
   logic [3:0]   k_q, k_d;
   logic         load_we;
   logic         accept;
   logic         drop_evt;

   weight_t      weight_q [NUM_TAPS];
   bias_t        bias_q;
   pixel_t       win_arr  [NUM_TAPS];
   product_t     prod_d   [NUM_TAPS];
   product_t     prod_q   [NUM_TAPS];
   bias_t        bias_s1_q, bias_s2_q;
   row_sum_t     row_d    [3];
   row_sum_t     row_q    [3];
   logic         v1_q, v2_q;

   logic signed [ACC_W-1:0] total;
   pixel_t       pix_d;
   pixel_t       data_q;
   logic         vout_q;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q_pos;
   logic         drop_q;

   assign win_arr[0] = win0;
   assign win_arr[1] = win1;
   assign win_arr[2] = win2;
   assign win_arr[3] = win3;
   assign win_arr[4] = win4;
   assign win_arr[5] = win5;
   assign win_arr[6] = win6;
   assign win_arr[7] = win7;
   assign win_arr[8] = win8;

   // A clear in the same cycle as a window wins silently: no drop is flagged.
   assign accept   = valid_in && (state_q == ST_RUN) && !w_clear;
   assign drop_evt = valid_in && (state_q == ST_LOAD) && !w_clear;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      load_we = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (w_clear) begin
               k_d = '0;
            end else if (w_valid) begin
               load_we = 1'b1;
               if (k_q == 4'(BIAS_SLOT)) begin
                  state_d = ST_RUN;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 4'd1;
               end
            end
         end
         ST_RUN: begin
            if (w_clear) begin
               state_d = ST_LOAD;
               k_d     = '0;
            end
         end
         default: begin
            state_d = ST_LOAD;
            k_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         k_q     <= '0;
         bias_q  <= '0;
         for (int i = 0; i < NUM_TAPS; i++) weight_q[i] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         for (int i = 0; i < NUM_TAPS; i++) begin
            if (load_we && (k_q == 4'(i))) weight_q[i] <= weight_t'(w_data[7:0]);
         end
         if (load_we && (k_q == 4'(BIAS_SLOT))) bias_q <= w_data;
      end
   end

   for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_mul
      assign prod_d[gi] = product_t'(win_arr[gi]) * product_t'(weight_q[gi]);
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      assign row_d[gi] = sext_prod(prod_q[3*gi]) + sext_prod(prod_q[3*gi+1])
                       + sext_prod(prod_q[3*gi+2]);
   end

   assign total = ACC_W'(row_q[0]) + ACC_W'(row_q[1]) + ACC_W'(row_q[2]) + ACC_W'(bias_s2_q);

   requant_relu_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .acc_i (total),
      .q_o   (pix_d)
   );

   // Bias travels with the products so in-flight windows survive a reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= '0;
         for (int i = 0; i < 3; i++) row_q[i] <= '0;
         bias_s1_q <= '0;
         bias_s2_q <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         data_q    <= '0;
         vout_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= prod_d[i];
         for (int i = 0; i < 3; i++) row_q[i] <= row_d[i];
         bias_s1_q <= bias_q;
         bias_s2_q <= bias_s1_q;
         v1_q      <= accept;
         v2_q      <= v1_q;
         data_q    <= v2_q ? pix_d : '0;
         vout_q    <= v2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q     <= '0;
         row_q_pos <= '0;
         drop_q    <= 1'b0;
      end else begin
         drop_q <= drop_q | drop_evt;
         if (w_clear) begin
            col_q     <= '0;
            row_q_pos <= '0;
         end else if (vout_q) begin
            if (col_q == COL_W'(OUT_W-1)) begin
               col_q     <= '0;
               row_q_pos <= (row_q_pos == ROW_W'(OUT_H-1)) ? '0 : row_q_pos + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end
      end
   end

   assign loaded     = (state_q == ST_RUN);
   assign data_out   = data_q;
   assign valid_out  = vout_q;
   assign out_col    = col_q;
   assign out_row    = row_q_pos;
   assign frame_done = vout_q && (col_q == COL_W'(OUT_W-1)) && (row_q_pos == ROW_W'(OUT_H-1));
   assign drop_err   = drop_q;

endmodule

// File: tb/tb_conv3x3_relu_pe.sv
// Bench for conv3x3_relu_pe: two instances (SHIFT=0 and SHIFT=7) share all stimulus;
// a scoreboard queue holds expected pixels and their due cycle.
module tb_conv3x3_relu_pe;

   localparam int OW = 6;
   localparam int OH = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic w_clear = 1'b0;
   logic w_valid = 1'b0;
   logic valid_in = 1'b0;
   logic signed [15:0] w_data = '0;
   logic signed [7:0]  win_tb [9];

   logic               loaded0, vout0, fd0, drop0;
   logic signed [7:0]  data0;
   logic [2:0]         col0, row0;
   logic               loaded7, vout7, fd7, drop7;
   logic signed [7:0]  data7;
   logic [2:0]         col7, row7;

   always #5 clk = ~clk;

   conv3x3_relu_pe #(.OUT_W(OW), .OUT_H(OH), .SHIFT(0), .ACC_W(20)) dut0 (
      .clk(clk), .rst_n(rst_n), .w_clear(w_clear), .w_valid(w_valid), .w_data(w_data),
      .loaded(loaded0), .valid_in(valid_in),
      .win0(win_tb[0]), .win1(win_tb[1]), .win2(win_tb[2]), .win3(win_tb[3]), .win4(win_tb[4]),
      .win5(win_tb[5]), .win6(win_tb[6]), .win7(win_tb[7]), .win8(win_tb[8]),
      .data_out(data0), .valid_out(vout0), .out_col(col0), .out_row(row0),
      .frame_done(fd0), .drop_err(drop0));

   conv3x3_relu_pe #(.OUT_W(OW), .OUT_H(OH), .SHIFT(7), .ACC_W(20)) dut7 (
      .clk(clk), .rst_n(rst_n), .w_clear(w_clear), .w_valid(w_valid), .w_data(w_data),
      .loaded(loaded7), .valid_in(valid_in),
      .win0(win_tb[0]), .win1(win_tb[1]), .win2(win_tb[2]), .win3(win_tb[3]), .win4(win_tb[4]),
      .win5(win_tb[5]), .win6(win_tb[6]), .win7(win_tb[7]), .win8(win_tb[8]),
      .data_out(data7), .valid_out(vout7), .out_col(col7), .out_row(row7),
      .frame_done(fd7), .drop_err(drop7));

   typedef struct {
      int e0;
      int e7;
      int cyc;
   } exp_t;

   typedef struct {
      string name;
      int    w;
      bit    single;
      int    bias;
      int    win;
      int    e0;
      int    e7;
   } vec_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mcol = 0;
   int mrow = 0;
   int fd_seen = 0;
   int kw [9];
   int kbias = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int model(input int sh);
      int t;
      int r;
      t = kbias;
      for (int i = 0; i < 9; i++) t += kw[i] * int'(win_tb[i]);
      if (t <= 0) return 0;
      r = (sh == 0) ? t : ((t + (1 << (sh - 1))) >>> sh);
      return (r > 127) ? 127 : r;
   endfunction

   // Output monitor: compares every valid_out against the scoreboard and position model.
   always @(negedge clk) begin
      exp_t r;
      if (!rst_n) begin
         mcol = 0;
         mrow = 0;
      end else begin
         if (vout0 || vout7) begin
            chk("valid_out_pair", int'(vout7), int'(vout0));
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid_out actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
               r = sb.pop_front();
               chk("data_shift0", int'(data0), r.e0);
               chk("data_shift7", int'(data7), r.e7);
               chk("latency_cycle", cyc, r.cyc);
               chk("out_col", int'(col0), mcol);
               chk("out_row", int'(row0), mrow);
               chk("frame_done", int'(fd0), (mcol == OW-1 && mrow == OH-1) ? 1 : 0);
               chk("frame_done_pair", int'(fd7), int'(fd0));
               if (fd0) fd_seen++;
               $display("out col=%0d row=%0d d0=%0d d7=%0d fd=%0d", col0, row0, data0, data7, fd0);
            end
         end else if (fd0 || fd7) begin
            checks++;
            failures++;
            $display("FAIL frame_done_without_valid actual=1 expected=0 (cycle %0d)", cyc);
         end
         if (w_clear) begin
            mcol = 0;
            mrow = 0;
         end else if (vout0) begin
            if (mcol == OW-1) begin
               mcol = 0;
               mrow = (mrow == OH-1) ? 0 : mrow + 1;
            end else begin
               mcol++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_win_all(input int v);
      for (int i = 0; i < 9; i++) win_tb[i] = 8'(v);
   endtask

   task automatic send_core(input bit push, input bit use_model, input int e0, input int e7);
      exp_t r;
      valid_in = 1'b1;
      if (push) begin
         r.e0  = use_model ? model(0) : e0;
         r.e7  = use_model ? model(7) : e7;
         r.cyc = cyc + 3;
         sb.push_back(r);
      end
      tick();
      valid_in = 1'b0;
   endtask

   task automatic send(input bit push);
      send_core(push, 1'b1, 0, 0);
   endtask

   task automatic load_kernel(input string tag);
      w_clear = 1'b1;
      tick();
      w_clear = 1'b0;
      for (int k = 0; k < 10; k++) begin
         w_valid = 1'b1;
         w_data  = (k < 9) ? {8'hA5, 8'(kw[k])} : 16'(kbias);
         if (k == 9) chk({tag, "_loaded_before_bias"}, int'(loaded0), 0);
         tick();
      end
      w_valid = 1'b0;
      chk({tag, "_loaded0"}, int'(loaded0), 1);
      chk({tag, "_loaded7"}, int'(loaded7), 1);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_drain_timeout actual=%0d expected=0 pending outputs", tag, sb.size());
         sb.delete();
      end
      repeat (3) tick();
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_data_out"},   int'(data0),   0);
      chk({tag, "_valid_out"},  int'(vout0),   0);
      chk({tag, "_out_col"},    int'(col0),    0);
      chk({tag, "_out_row"},    int'(row0),    0);
      chk({tag, "_frame_done"}, int'(fd0),     0);
      chk({tag, "_loaded"},     int'(loaded0), 0);
      chk({tag, "_drop_err"},   int'(drop0),   0);
      chk({tag, "_data_out7"},  int'(data7),   0);
      chk({tag, "_valid_out7"}, int'(vout7),   0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [9];
      vecs[0] = '{"ones_bias0",    1,   1'b0,    0,   10,  90,   1};
      vecs[1] = '{"relu_neg",      1,   1'b0, -100,   10,   0,   0};
      vecs[2] = '{"saturate",      127, 1'b0,    0,  127, 127, 127};
      vecs[3] = '{"round_in64",    1,   1'b1,    0,   64,  64,   1};
      vecs[4] = '{"round_in63",    1,   1'b1,    0,   63,  63,   0};
      vecs[5] = '{"round_bias191", 1,   1'b1,  191,    0, 127,   1};
      vecs[6] = '{"round_bias192", 1,   1'b1,  192,    0, 127,   2};
      vecs[7] = '{"neg_w_neg_win", -1,  1'b0,    0,   -5,  45,   0};
      vecs[8] = '{"mid_scale",     2,   1'b0, 1000,  100, 127,  22};

      set_win_all(0);
      for (int i = 0; i < 9; i++) kw[i] = 0;

      rst_n = 1'b0;
      repeat (3) tick();
      check_idle_zero("reset");
      rst_n = 1'b1;
      tick();

      // Windows before any kernel is loaded are dropped and flagged.
      set_win_all(10);
      send(1'b0);
      repeat (4) tick();
      chk("early_drop_err0", int'(drop0), 1);
      chk("early_drop_err7", int'(drop7), 1);
      chk("early_loaded", int'(loaded0), 0);

      rst_n = 1'b0;
      tick();
      chk("reset_clears_drop_err", int'(drop0), 0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < 9; i++) kw[i] = (vecs[v].single && i != 8) ? 0 : vecs[v].w;
         kbias = vecs[v].bias;
         load_kernel(vecs[v].name);
         set_win_all(vecs[v].win);
         send_core(1'b1, 1'b0, vecs[v].e0, vecs[v].e7);
         wait_drain(vecs[v].name);
      end

      // Two frames: the first back-to-back, the second with random idle gaps.
      for (int i = 0; i < 9; i++) kw[i] = i - 4;
      kbias = 37;
      load_kernel("frame");
      fd_seen = 0;
      for (int n = 0; n < 2 * OW * OH; n++) begin
         for (int i = 0; i < 9; i++) win_tb[i] = 8'($urandom_range(0, 255));
         send(1'b1);
         if (n >= OW * OH) repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain("frame");
      chk("frame_done_count", fd_seen, 2);
      chk("frame_wrap_col", int'(col0), 0);
      chk("frame_wrap_row", int'(row0), 0);

      // Clear one cycle after a window: that window drains, later ones drop.
      for (int i = 0; i < 9; i++) kw[i] = 1;
      kbias = 0;
      load_kernel("clr");
      set_win_all(3);
      send(1'b1);
      w_clear  = 1'b1;
      valid_in = 1'b1;
      set_win_all(5);
      tick();
      w_clear  = 1'b0;
      valid_in = 1'b0;
      chk("clr_same_cycle_no_drop", int'(drop0), 0);
      chk("clr_loaded_low", int'(loaded0), 0);
      send(1'b0);
      chk("clr_next_window_drop", int'(drop0), 1);
      wait_drain("clr");

      // Asynchronous reset with two windows in flight discards them.
      for (int i = 0; i < 9; i++) kw[i] = 2;
      kbias = 5;
      load_kernel("rst");
      set_win_all(7);
      send(1'b1);
      send(1'b1);
      rst_n = 1'b0;
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check_idle_zero("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
